regfile_multiport: RTL and testbench

- Parametrised successor to the pipeline's 2-read/1-write register file.
- Width, depth and read-port count are parameters; writes are on the rising edge; reads are combinational with optional write-to-read bypass.
- A per-entry reset-to-one mask generalises the fixed "constant 1" registers.
- A sequential clear engine re-initialises the whole array on request without a global reset.
- Sits in the ID stage, feeding the ID/EX latch; written from WB.

---
 rtl/regfile_pkg.sv | 27 ++
 rtl/regfile_clear_fsm.sv | 64 ++++++
 rtl/regfile_multiport.sv | 90 +++++++++
 tb/tb_regfile_multiport.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared types and helpers for the multi-port register file and its clear engine.
package regfile_pkg;

  localparam int unsigned MAX_WIDTH = 64;
  localparam int unsigned MAX_DEPTH = 64;
  localparam int unsigned IDX_W     = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    DONE  = 2'd2
  } clr_state_e;

  function automatic int unsigned addr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Reset/clear value of one entry: 1 when its mask bit is set, else 0.
  function automatic logic [MAX_WIDTH-1:0] reset_val(input logic [IDX_W-1:0]     idx,
                                                     input logic [MAX_DEPTH-1:0] mask);
    logic [MAX_WIDTH-1:0] v;
    v    = '0;
    v[0] = mask[idx];
    return v;
  endfunction

endpackage

// File: rtl/regfile_clear_fsm.sv
// Sequential clear engine: walks every entry once, writing its reset value.
module regfile_clear_fsm
  import regfile_pkg::*;
#(
  parameter int unsigned          WIDTH = 32,
  parameter int unsigned          DEPTH = 32,
  parameter logic [DEPTH-1:0]     MASK  = 32'hC000_0000,
  localparam int unsigned         AW    = addr_width(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clr_req,
  output logic             clr_busy,
  output logic             clr_done,
  output logic             clear_we,
  output logic [AW-1:0]    clear_addr,
  output logic [WIDTH-1:0] clear_data
);

  clr_state_e    state, state_d;
  logic [AW-1:0] idx, idx_d;
  logic          busy_d, done_d;

  always_comb begin
    state_d = state;
    idx_d   = idx;
    case (state)
      IDLE: begin
        if (clr_req) begin
          state_d = CLEAR;
          idx_d   = '0;
        end
      end
      CLEAR: begin
        if (idx == AW'(DEPTH - 1)) state_d = DONE;
        else                       idx_d   = idx + AW'(1);
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Flags are registered copies of the next-state decode.
    busy_d = (state_d == CLEAR);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      idx      <= '0;
      clr_busy <= 1'b0;
      clr_done <= 1'b0;
    end else begin
      state    <= state_d;
      idx      <= idx_d;
      clr_busy <= busy_d;
      clr_done <= done_d;
    end
  end

  assign clear_we   = clr_busy;
  assign clear_addr = idx;
  assign clear_data = WIDTH'(reset_val(IDX_W'(idx), MAX_DEPTH'(MASK)));

endmodule

// File: rtl/regfile_multiport.sv
// Parametrised N-read/1-write register file with bypass, reset mask and clear engine.
// Optional: define REGFILE_ZERO_REG_EN to hard-wire entry 0 to zero.
module regfile_multiport
  import regfile_pkg::*;
#(
  parameter int unsigned      WIDTH          = 32,
  parameter int unsigned      DEPTH          = 32,
  parameter int unsigned      NUM_RD         = 2,
  parameter int unsigned      BYPASS         = 1,
  parameter logic [DEPTH-1:0] RESET_ONE_MASK = 32'hC000_0000,
  localparam int unsigned     AW             = addr_width(DEPTH)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NUM_RD*AW-1:0]    rd_addr,
  output logic [NUM_RD*WIDTH-1:0] rd_data,
  input  logic                    wr_en,
  input  logic [AW-1:0]           wr_addr,
  input  logic [WIDTH-1:0]        wr_data,
  input  logic                    clr_req,
  output logic                    clr_busy,
  output logic                    clr_done
);

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO_REG = 1'b1;
`else
  localparam bit ZERO_REG = 1'b0;
`endif

  localparam logic [DEPTH-1:0] EFF_MASK =
    ZERO_REG ? (RESET_ONE_MASK & ~DEPTH'(1)) : RESET_ONE_MASK;

  logic             clear_we;
  logic [AW-1:0]    clear_addr;
  logic [WIDTH-1:0] clear_data;
  logic             wr_commit;
  logic [WIDTH-1:0] mem [DEPTH];

  regfile_clear_fsm #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .MASK  (EFF_MASK)
  ) u_clear (
    .clock      (clock),
    .reset      (reset),
    .clr_req    (clr_req),
    .clr_busy   (clr_busy),
    .clr_done   (clr_done),
    .clear_we   (clear_we),
    .clear_addr (clear_addr),
    .clear_data (clear_data)
  );

  // User write loses to a clear write on the same entry.
  always_comb begin
    wr_commit = wr_en
              && (32'(wr_addr) < DEPTH)
              && !(clear_we && (clear_addr == wr_addr))
              && !(ZERO_REG && (wr_addr == '0));
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem[i] <= WIDTH'(reset_val(IDX_W'(i), MAX_DEPTH'(EFF_MASK)));
      end
    end else begin
      if (clear_we)  mem[clear_addr] <= clear_data;
      if (wr_commit) mem[wr_addr]    <= wr_data;
    end
  end

  for (genvar k = 0; k < int'(NUM_RD); k++) begin : g_rd
    logic [AW-1:0]    ra;
    logic [WIDTH-1:0] rv;

    assign ra = rd_addr[k*AW +: AW];

    always_comb begin
      rv = '0;
      if (32'(ra) < DEPTH)                                  rv = mem[ra];
      if ((BYPASS != 0) && wr_commit && (wr_addr == ra))    rv = wr_data;
      if (ZERO_REG && (ra == '0))                           rv = '0;
    end

    assign rd_data[k*WIDTH +: WIDTH] = rv;
  end

endmodule

// File: tb/tb_regfile_multiport.sv
// Scoreboard bench for regfile_multiport (BYPASS=1 and BYPASS=0 instances).
module tb_regfile_multiport;

  localparam int unsigned W  = 32;
  localparam int unsigned D  = 32;
  localparam int unsigned AW = 5;
  localparam int unsigned NR = 2;

`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZR = 1'b1;
`else
  localparam bit ZR = 1'b0;
`endif

  logic            clock = 1'b0;
  logic            reset;
  logic [NR*AW-1:0] rd_addr;
  logic [NR*W-1:0]  rd_data, rd_data_nb;
  logic            wr_en;
  logic [AW-1:0]   wr_addr;
  logic [W-1:0]    wr_data;
  logic            clr_req;
  logic            clr_busy, clr_done, clr_busy_nb, clr_done_nb;

  typedef struct {
    string        tag;
    logic [W-1:0] val;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] model [D];
  int           n_checks = 0;
  int           n_fail   = 0;
  int           busy_cnt;

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .BYPASS(1), .RESET_ONE_MASK(32'hC000_0000)
  ) dut (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy), .clr_done(clr_done)
  );

  regfile_multiport #(
    .WIDTH(W), .DEPTH(D), .NUM_RD(NR), .BYPASS(0), .RESET_ONE_MASK(32'hC000_0000)
  ) dut_nb (
    .clock(clock), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_nb),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .clr_req(clr_req), .clr_busy(clr_busy_nb), .clr_done(clr_done_nb)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(D); i++) model[i] = (i >= 30) ? 32'd1 : 32'd0;
  endtask

  task automatic set_rd(input int k, input logic [AW-1:0] a);
    rd_addr[k*AW +: AW] = a;
  endtask

  task automatic expect_rd(input string tag, input logic [W-1:0] e);
    exp_q.push_back('{tag, e});
  endtask

  // Pop the oldest expectation and compare it with the selected instance/port.
  task automatic compare_rd(input int which, input int k);
    exp_t         e;
    logic [W-1:0] got;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL sb_underflow: got no expectation for port %0d", k);
      return;
    end
    e   = exp_q.pop_front();
    got = (which == 0) ? rd_data[k*W +: W] : rd_data_nb[k*W +: W];
    check(e.tag, got, e.val);
  endtask

  task automatic read_model(input int which, input int k, input logic [AW-1:0] a, input string tag);
    @(negedge clock);
    set_rd(k, a);
    expect_rd($sformatf("%s_a%0d", tag, a), model[a]);
    #1;
    compare_rd(which, k);
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [W-1:0] d);
    @(negedge clock);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    if (!(ZR && a == '0)) model[a] = d;
  endtask

  task automatic read_all(input string tag);
    for (int a = 0; a < int'(D); a++) read_model(0, a % 2, AW'(a), tag);
  endtask

  task automatic start_clear();
    @(negedge clock);
    clr_req = 1'b1;
    @(posedge clock);
    #1;
    clr_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    reset   = 1'b0;
    rd_addr = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    clr_req = 1'b0;
    model_reset();
    #12 reset = 1'b1;

    // Reset state
    read_all("rst");
    check("rst_busy", W'(clr_busy), 32'd0);
    check("rst_done", W'(clr_done), 32'd0);
    read_model(1, 1, 5'd31, "rst_nb");

    // Write then read on both ports
    do_write(5'd5, 32'hDEAD_BEEF);
    read_model(0, 0, 5'd5, "wr5_p0");
    read_model(0, 1, 5'd5, "wr5_p1");

    // Same-cycle bypass vs no bypass
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'd42;
    set_rd(1, 5'd7);
    expect_rd("byp_on",  32'd42);
    expect_rd("byp_off", model[7]);
    #1;
    compare_rd(0, 1);
    compare_rd(1, 1);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    model[7] = 32'd42;
    read_model(1, 1, 5'd7, "byp_off_after");

    // Clear engine with concurrent user writes
    do_write(5'd3, 32'd9);
    do_write(5'd31, 32'd11);
    read_model(0, 0, 5'd3, "pre_clr");
    read_model(0, 1, 5'd31, "pre_clr");
    start_clear();
    busy_cnt = 0;
    while (clr_busy === 1'b1 && busy_cnt < 100) begin
      wr_en = 1'b0;
      if (busy_cnt == 10) begin
        wr_en = 1'b1; wr_addr = 5'd20; wr_data = 32'h2020;
      end
      if (busy_cnt == 11) begin
        set_rd(0, 5'd20);
        expect_rd("clr_wr20_live", 32'h2020);
        #1;
        compare_rd(0, 0);
      end
      if (busy_cnt == 12) begin
        wr_en = 1'b1; wr_addr = 5'd12; wr_data = 32'h1212;
        set_rd(1, 5'd12);
        expect_rd("clr_collide_nobyp", 32'd0);
        #1;
        compare_rd(0, 1);
      end
      if (busy_cnt == 13) begin
        set_rd(1, 5'd12);
        expect_rd("clr_wr12_dropped", 32'd0);
        #1;
        compare_rd(0, 1);
      end
      @(posedge clock);
      #1;
      busy_cnt++;
    end
    wr_en = 1'b0;
    check("clr_busy_cycles", W'(busy_cnt), 32'd32);
    check("clr_done_pulse", W'(clr_done), 32'd1);
    check("clr_busy_in_done", W'(clr_busy), 32'd0);
    @(posedge clock);
    #1;
    check("clr_done_one_cycle", W'(clr_done), 32'd0);
    check("clr_idle_busy", W'(clr_busy), 32'd0);
    model_reset();
    read_all("post_clr");

    // Reset asserted mid-clear at idx 15
    do_write(5'd2, 32'h55);
    do_write(5'd30, 32'h66);
    start_clear();
    repeat (15) @(posedge clock);
    #1;
    check("midclr_busy_before", W'(clr_busy), 32'd1);
    reset = 1'b0;
    #1;
    check("midclr_busy", W'(clr_busy), 32'd0);
    check("midclr_done", W'(clr_done), 32'd0);
    model_reset();
    read_all("midclr_rst");
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    check("midclr_idle_busy", W'(clr_busy), 32'd0);
    check("midclr_idle_done", W'(clr_done), 32'd0);

    // Entry 0: hard-wired zero when enabled, ordinary otherwise
    @(negedge clock);
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'd77;
    set_rd(0, 5'd0);
    expect_rd("zr_bypass", ZR ? 32'd0 : 32'd77);
    #1;
    compare_rd(0, 0);
    @(posedge clock);
    #1;
    wr_en = 1'b0;
    if (!ZR) model[0] = 32'd77;
    read_model(0, 0, 5'd0, "zr_after");
    read_model(1, 1, 5'd0, "zr_after_nb");

    check("sb_empty", W'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
